// File: rtl/decoder_pkg.sv
// Shared decoder/UART definitions: word type, scheduler state encoding and the
// default header magic used when a new channel takes the transmitter.
package decoder_pkg;

    typedef logic [31:0] word;

    localparam logic [23:0] UartHdrMagic = 24'hA5_5A_C3;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } uart_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set bit of mask at or after start,
// wrapping modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] pos;

    // Walk from the farthest candidate back to start so the nearest hit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(N)) begin
                pos = pos - (IW + 1)'(N);
            end
            if (mask[pos[IW-1:0]]) begin
                idx = pos[IW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one word-oriented UART transmitter between NumReq producer FIFOs,
// round-robin with bounded bursts and a channel header on owner change.
module uart_tx_sched
    import decoder_pkg::*;
#(
    parameter  int          NumReq   = 4,
    parameter  int          BurstMax = 4,
    parameter  bit          HdrEn    = 1'b1,
    parameter  logic [23:0] HdrMagic = UartHdrMagic,
    localparam int          IdxW     = $clog2(NumReq)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NumReq-1:0]      req_valid_i,
    input  word  [NumReq-1:0]      req_data_i,
    output logic [NumReq-1:0]      req_pop_o,
    output word                    uart_d_o,
    output logic                   uart_rts_o,
    input  logic                   uart_next_i,
    output logic [IdxW-1:0]        grant_o,
    output logic                   busy_o
);

    localparam int CntW = $clog2(BurstMax + 1);

    uart_sched_state_t state, state_nxt;
    logic [IdxW-1:0]   grant, last_grant, owner;
    logic              owner_vld;
    logic [CntW-1:0]   burst_cnt;

    logic [IdxW-1:0]   arb_start, arb_idx;
    logic              arb_any;
    logic [NumReq-1:0] grant_oh;
    logic              grant_vld, take, other_vld, burst_hit, burst_sat;

    assign arb_start = (int'(last_grant) == NumReq - 1) ? '0 : last_grant + 1'b1;

    rr_arbiter #(.N(NumReq)) u_arb (
        .mask  (req_valid_i),
        .start (arb_start),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        grant_oh        = '0;
        grant_oh[grant] = 1'b1;
    end

    assign grant_vld = req_valid_i[grant];
    assign take      = (state == DATA) && uart_next_i && grant_vld;
    assign other_vld = |(req_valid_i & ~grant_oh);
    assign burst_hit = (int'(burst_cnt) + 1 >= BurstMax);
    // Saturating one short of the limit keeps the switch armed for a late competitor.
    assign burst_sat = (int'(burst_cnt) >= BurstMax - 1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IdxW'(NumReq - 1);
            owner      <= '0;
            owner_vld  <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant     <= arb_idx;
                        burst_cnt <= '0;
                    end
                end
                HDR: begin
                    if (uart_next_i) begin
                        owner     <= grant;
                        owner_vld <= 1'b1;
                    end
                end
                DATA: begin
                    if (take) begin
                        last_grant <= grant;
                        if (!burst_sat) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (!grant_vld) begin
                        last_grant <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        uart_rts_o = 1'b0;
        uart_d_o   = '0;
        req_pop_o  = '0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt = (HdrEn && !(owner_vld && owner == arb_idx)) ? HDR : DATA;
                end
            end
            HDR: begin
                uart_rts_o = 1'b1;
                uart_d_o   = {8'(grant), HdrMagic};
                if (uart_next_i) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                uart_rts_o       = grant_vld;
                uart_d_o         = req_data_i[grant];
                req_pop_o[grant] = take;
                if (!grant_vld || (take && burst_hit && other_vld)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_o = grant;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: FIFO-queue producers, random UART acceptance and a
// transaction-level scheduling model producing the expected UART word stream.
module tb_uart_tx_sched;

    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid [2];
    logic [NR-1:0][31:0] req_data;
    logic [NR-1:0]    pop [2];
    logic [31:0]      dout [2];
    logic             rts [2];
    logic             nxt [2];
    logic [1:0]       grant [2];
    logic             busy [2];

    uart_tx_sched #(.NumReq(NR), .BurstMax(4), .HdrEn(1'b1)) dut0 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid[0]), .req_data_i(req_data),
        .req_pop_o(pop[0]), .uart_d_o(dout[0]), .uart_rts_o(rts[0]), .uart_next_i(nxt[0]),
        .grant_o(grant[0]), .busy_o(busy[0])
    );

    uart_tx_sched #(.NumReq(NR), .BurstMax(1), .HdrEn(1'b0)) dut1 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid[1]), .req_data_i(req_data),
        .req_pop_o(pop[1]), .uart_d_o(dout[1]), .uart_rts_o(rts[1]), .uart_next_i(nxt[1]),
        .grant_o(grant[1]), .busy_o(busy[1])
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] fq [NR][$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          pop_q[$];
    int          first_rts;
    int          hdr_seen;
    int          m_last [2];
    int          m_owner [2];
    bit          m_own_v [2];
    int          m_burst [2] = '{4, 1};
    bit          m_hdr [2] = '{1'b1, 1'b0};

    function automatic logic [31:0] hdr(input int g);
        return {8'(g), 24'hA55AC3};
    endfunction

    // Reference: replay the whole queue contents as grants/bursts.
    task automatic model_expected(input int sel);
        logic [31:0] mq [NR][$];
        int g, n;
        bit any, others;
        exp_q.delete();
        for (int i = 0; i < NR; i++) mq[i] = fq[i];
        forever begin
            any = 0;
            for (int i = 0; i < NR; i++) if (mq[i].size() > 0) any = 1;
            if (!any) break;
            g = -1;
            for (int k = 1; k <= NR; k++)
                if (g < 0 && mq[(m_last[sel] + k) % NR].size() > 0) g = (m_last[sel] + k) % NR;
            if (m_hdr[sel] && !(m_own_v[sel] && m_owner[sel] == g)) begin
                exp_q.push_back(hdr(g));
                m_owner[sel] = g;
                m_own_v[sel] = 1'b1;
            end
            n = 0;
            forever begin
                exp_q.push_back(mq[g].pop_front());
                n++;
                m_last[sel] = g;
                if (mq[g].size() == 0) break;
                others = 0;
                for (int i = 0; i < NR; i++) if (i != g && mq[i].size() > 0) others = 1;
                if (n >= m_burst[sel] && others) break;
            end
        end
    endtask

    task automatic drive(input int sel);
        for (int i = 0; i < NR; i++) begin
            req_valid[sel][i] = (fq[i].size() > 0);
            req_data[i] = (fq[i].size() > 0) ? fq[i][0] : $urandom();
        end
        nxt[sel] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic run_stream(input int sel);
        bit done = 0;
        bit all_empty;
        int idx;
        model_expected(sel);
        obs_q.delete();
        pop_q.delete();
        first_rts = -1;
        hdr_seen = 0;
        @(posedge clk); #1;
        drive(sel);
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (first_rts < 0 && rts[sel]) first_rts = c;
            if (rts[sel] && nxt[sel]) begin
                obs_q.push_back(dout[sel]);
                if (pop[sel] == '0) hdr_seen++;
            end
            if (pop[sel] != '0) begin
                n_cmp++;
                if (!$onehot(pop[sel]) || pop[sel] != (4'b1 << grant[sel]) || !(rts[sel] && nxt[sel])) begin
                    n_fail++;
                    $display("FAIL pop_check dut%0d: pop=%b grant=%0d rts=%b next=%b (want one-hot on grant, only when rts&&next)",
                             sel, pop[sel], grant[sel], rts[sel], nxt[sel]);
                end
                idx = int'(grant[sel]);
                pop_q.push_back(idx);
                if (fq[idx].size() > 0) void'(fq[idx].pop_front());
            end
            all_empty = 1;
            for (int i = 0; i < NR; i++) if (fq[i].size() > 0) all_empty = 0;
            if (all_empty && !busy[sel]) done = 1;
            else begin
                @(posedge clk); #1;
                drive(sel);
            end
        end
        nxt[sel] = 1'b0;
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout dut%0d: stream did not drain within 2000 cycles", sel);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stream_len dut%0d: got %0d words, want %0d", sel, obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL stream_word dut%0d[%0d]: got %h, want %h", sel, k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = '0;
            nxt[s] = 1'b0;
            m_last[s] = NR - 1;
            m_owner[s] = 0;
            m_own_v[s] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if (rts[s] !== 1'b0 || pop[s] !== '0 || dout[s] !== '0 || grant[s] !== '0 || busy[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: rts=%b pop=%b d=%h grant=%0d busy=%b, want all zero",
                         s, rts[s], pop[s], dout[s], grant[s], busy[s]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        fq[0] = '{32'h11223344, 32'h55667788};
        run_stream(0);
        n_cmp++;
        if (first_rts != 1) begin
            n_fail++;
            $display("FAIL single_latency: rts first high at cycle %0d, want 1", first_rts);
        end
        n_cmp++;
        if (obs_q.size() < 1 || obs_q[0] !== 32'h00A55AC3) begin
            n_fail++;
            $display("FAIL single_header: got %h, want 00a55ac3", (obs_q.size() > 0) ? obs_q[0] : 32'hx);
        end
        n_cmp++;
        if (pop_q.size() != 2 || pop_q[0] != 0 || pop_q[1] != 0) begin
            n_fail++;
            $display("FAIL single_pops: got %0d pops, want 2 on req0", pop_q.size());
        end
    endtask

    task automatic test_same_owner();
        fq[0] = '{32'hDEADBEEF};
        run_stream(0);
        n_cmp++;
        if (first_rts != 1 || hdr_seen != 0) begin
            n_fail++;
            $display("FAIL same_owner: rts at %0d hdrs %0d, want rts at 1 and no header", first_rts, hdr_seen);
        end
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 6; k++) begin
            fq[1].push_back($urandom());
            fq[2].push_back($urandom());
        end
        run_stream(0);
        n_cmp++;
        if (hdr_seen != 4) begin
            n_fail++;
            $display("FAIL rr_headers: got %0d headers, want 4", hdr_seen);
        end
    endtask

    task automatic test_valid_drop();
        fq[1].push_back($urandom());
        run_stream(0);
        fq[2].push_back($urandom());
        for (int k = 0; k < 3; k++) fq[1].push_back($urandom());
        run_stream(0);
        n_cmp++;
        if (obs_q.size() < 3 || obs_q[2] !== hdr(1)) begin
            n_fail++;
            $display("FAIL drop_regrant: word[2]=%h, want %h", (obs_q.size() > 2) ? obs_q[2] : 32'hx, hdr(1));
        end
    endtask

    task automatic test_reset_mid_hdr();
        fq[3] = '{$urandom(), $urandom()};
        @(posedge clk); #1;
        drive(0);
        nxt[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (rts[0] !== 1'b1 || dout[0] !== hdr(3) || pop[0] !== '0) begin
            n_fail++;
            $display("FAIL hdr_state: rts=%b d=%h pop=%b, want 1 %h 0000", rts[0], dout[0], pop[0], hdr(3));
        end
        reset = 1'b1;
        nxt[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (rts[0] !== 1'b0 || pop[0] !== '0 || busy[0] !== 1'b0 || grant[0] !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_hdr: rts=%b pop=%b busy=%b grant=%0d, want all zero", rts[0], pop[0], busy[0], grant[0]);
        end
        reset = 1'b0;
        nxt[0] = 1'b0;
        req_valid[0] = '0;
        for (int s = 0; s < 2; s++) begin
            m_last[s] = NR - 1;
            m_own_v[s] = 1'b0;
        end
        run_stream(0);
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 6; k++) begin
            fq[0].push_back($urandom());
            fq[3].push_back($urandom());
        end
        run_stream(1);
        n_cmp++;
        if (pop_q.size() != 12) begin
            n_fail++;
            $display("FAIL starve_count: got %0d pops, want 12", pop_q.size());
        end
        for (int k = 0; k < pop_q.size(); k++) begin
            n_cmp++;
            if (pop_q[k] != ((k % 2 == 0) ? 0 : 3)) begin
                n_fail++;
                $display("FAIL starve_grant[%0d]: got %0d, want %0d", k, pop_q[k], (k % 2 == 0) ? 0 : 3);
            end
        end
    endtask

    task automatic test_hdr_off();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NR; i++)
                repeat ($urandom_range(0, 5)) fq[i].push_back($urandom());
            fq[$urandom_range(0, NR - 1)].push_back($urandom());
            run_stream(1);
            n_cmp++;
            if (hdr_seen != 0) begin
                n_fail++;
                $display("FAIL hdr_off: got %0d header words, want 0", hdr_seen);
            end
        end
    endtask

    initial begin
        req_valid[0] = '0;
        req_valid[1] = '0;
        nxt[0] = 1'b0;
        nxt[1] = 1'b0;
        req_data = '0;
        test_reset();
        test_single();
        test_same_owner();
        test_round_robin();
        test_valid_drop();
        test_reset_mid_hdr();
        test_starvation();
        test_hdr_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
